// File: rtl/noc_pkg.sv
// Shared router constants: output direction codes, crossbar select codes, port indices
// and the per-output allocation state type.
package noc_pkg;

    localparam int unsigned N_PORTS = 5;

    localparam logic [2:0] OUT_L = 3'd0;
    localparam logic [2:0] OUT_E = 3'd1;
    localparam logic [2:0] OUT_W = 3'd2;
    localparam logic [2:0] OUT_N = 3'd3;
    localparam logic [2:0] OUT_S = 3'd4;

    localparam logic [2:0] IN_L   = 3'd0;
    localparam logic [2:0] IN_N   = 3'd1;
    localparam logic [2:0] IN_E   = 3'd2;
    localparam logic [2:0] IN_S   = 3'd3;
    localparam logic [2:0] IN_W   = 3'd4;
    localparam logic [2:0] IN_NON = 3'd5;

    localparam int unsigned PORT_L = 0;
    localparam int unsigned PORT_N = 1;
    localparam int unsigned PORT_E = 2;
    localparam int unsigned PORT_S = 3;
    localparam int unsigned PORT_W = 4;

    typedef logic [0:0] alloc_state_t;
    localparam alloc_state_t IDLE   = 1'b0;
    localparam alloc_state_t LOCKED = 1'b1;

    // Direction code that a flit carries to reach the output at a given port index.
    function automatic logic [2:0] out_code(int unsigned port);
        case (port)
            PORT_L:  return OUT_L;
            PORT_N:  return OUT_N;
            PORT_E:  return OUT_E;
            PORT_S:  return OUT_S;
            default: return OUT_W;
        endcase
    endfunction

    function automatic logic [2:0] wrap_inc(logic [2:0] idx);
        return (idx >= 3'd4) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/wormhole_switch_allocator_arb.sv
// One output's wormhole arbiter: round-robin pick while idle, hold the winner until its
// tail flit transfers.
module rr_out_arbiter
    import noc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] eligible,
    input  logic       owner_valid,
    input  logic       owner_tail,
    input  logic       full,
    output logic [4:0] grant,
    output logic [2:0] select,
    output logic       lock
);

    alloc_state_t state_q, state_d;
    logic [2:0]   ptr_q, ptr_d;
    logic [2:0]   sel_q, sel_d;
    logic [2:0]   winner;
    logic [2:0]   idx;
    logic [7:0]   elig_ext;
    logic         found;
    logic         xfer;

    assign elig_ext = {3'b000, eligible};

    always_comb begin
        found  = 1'b0;
        winner = IN_NON;
        idx    = ptr_q;
        for (int k = 0; k < 5; k++) begin
            if (!found && elig_ext[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = wrap_inc(idx);
        end
    end

    assign xfer  = (state_q == LOCKED) && owner_valid && !full;
    assign grant = xfer ? (5'b00001 << sel_q) : 5'b00000;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOCKED;
                    sel_d   = winner;
                    ptr_d   = wrap_inc(winner);
                end
            end
            default: begin
                if (xfer && owner_tail) begin
                    state_d = IDLE;
                    sel_d   = IN_NON;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            sel_q   <= IN_NON;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

    assign select = sel_q;
    assign lock   = (state_q == LOCKED);

endmodule

// File: rtl/wormhole_switch_allocator.sv
// Five-port wormhole switch allocator: one round-robin arbiter per output, grants ORed
// into per-input dequeue strobes.
module wormhole_switch_allocator
    import noc_pkg::*;
#(
    parameter int unsigned N_BIT_SEL  = 3,
    parameter int unsigned N_REGISTER = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_L,
    input  logic                  req_valid_N,
    input  logic                  req_valid_E,
    input  logic                  req_valid_S,
    input  logic                  req_valid_W,
    input  logic [N_REGISTER-1:0] request_L,
    input  logic [N_REGISTER-1:0] request_N,
    input  logic [N_REGISTER-1:0] request_E,
    input  logic [N_REGISTER-1:0] request_S,
    input  logic [N_REGISTER-1:0] request_W,
    input  logic                  tail_L,
    input  logic                  tail_N,
    input  logic                  tail_E,
    input  logic                  tail_S,
    input  logic                  tail_W,
    input  logic                  full_L,
    input  logic                  full_N,
    input  logic                  full_E,
    input  logic                  full_S,
    input  logic                  full_W,
    output logic                  grant_L,
    output logic                  grant_N,
    output logic                  grant_E,
    output logic                  grant_S,
    output logic                  grant_W,
    output logic [N_BIT_SEL-1:0]  select_L,
    output logic [N_BIT_SEL-1:0]  select_N,
    output logic [N_BIT_SEL-1:0]  select_E,
    output logic [N_BIT_SEL-1:0]  select_S,
    output logic [N_BIT_SEL-1:0]  select_W,
    output logic                  lock_L,
    output logic                  lock_N,
    output logic                  lock_E,
    output logic                  lock_S,
    output logic                  lock_W
);

    logic [4:0]            valid_vec, tail_vec, full_vec, lock_vec, owner_valid, owner_tail;
    logic [4:0]            grant_all;
    logic [N_REGISTER-1:0] req_arr   [N_PORTS];
    logic [4:0]            elig      [N_PORTS];
    logic [4:0]            grant_arr [N_PORTS];
    logic [2:0]            sel_arr   [N_PORTS];

    assign valid_vec = {req_valid_W, req_valid_S, req_valid_E, req_valid_N, req_valid_L};
    assign tail_vec  = {tail_W, tail_S, tail_E, tail_N, tail_L};
    assign full_vec  = {full_W, full_S, full_E, full_N, full_L};

    assign req_arr[PORT_L] = request_L;
    assign req_arr[PORT_N] = request_N;
    assign req_arr[PORT_E] = request_E;
    assign req_arr[PORT_S] = request_S;
    assign req_arr[PORT_W] = request_W;

    // Illegal codes 5-7 never equal any output's code, so they are never eligible.
    always_comb begin
        for (int o = 0; o < N_PORTS; o++) begin
            owner_valid[o] = 1'b0;
            owner_tail[o]  = 1'b0;
            for (int i = 0; i < N_PORTS; i++) begin
                elig[o][i] = valid_vec[i] &&
                             (req_arr[i] == N_REGISTER'(out_code(int'(o))));
                if (sel_arr[o] == 3'(i)) begin
                    owner_valid[o] = valid_vec[i];
                    owner_tail[o]  = tail_vec[i];
                end
            end
        end
    end

    for (genvar o = 0; o < N_PORTS; o++) begin : g_out
        rr_out_arbiter u_arb (
            .clk         (clk),
            .rst         (rst),
            .eligible    (elig[o]),
            .owner_valid (owner_valid[o]),
            .owner_tail  (owner_tail[o]),
            .full        (full_vec[o]),
            .grant       (grant_arr[o]),
            .select      (sel_arr[o]),
            .lock        (lock_vec[o])
        );
    end

    always_comb begin
        grant_all = 5'b00000;
        for (int o = 0; o < N_PORTS; o++) begin
            grant_all = grant_all | grant_arr[o];
        end
    end

    assign {grant_W, grant_S, grant_E, grant_N, grant_L} = grant_all;
    assign {lock_W, lock_S, lock_E, lock_N, lock_L}      = lock_vec;

    assign select_L = N_BIT_SEL'(sel_arr[PORT_L]);
    assign select_N = N_BIT_SEL'(sel_arr[PORT_N]);
    assign select_E = N_BIT_SEL'(sel_arr[PORT_E]);
    assign select_S = N_BIT_SEL'(sel_arr[PORT_S]);
    assign select_W = N_BIT_SEL'(sel_arr[PORT_W]);

endmodule

// File: tb/tb_wormhole_switch_allocator.sv
// Scoreboard bench: stimulus pushes per-cycle expectations from a packet-level model,
// a negedge monitor pops and compares them against the allocator outputs.
module tb_wormhole_switch_allocator;

    typedef struct packed {
        logic [4:0]  grant;
        logic [14:0] sel;
        logic [4:0]  lock;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] valid, tail, full;
    logic [2:0] req [5];
    wire        g_l, g_n, g_e, g_s, g_w, k_l, k_n, k_e, k_s, k_w;
    wire  [2:0] s_l, s_n, s_e, s_s, s_w;

    always #5 clk = ~clk;

    wormhole_switch_allocator #(.N_BIT_SEL(3), .N_REGISTER(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid_L(valid[0]), .req_valid_N(valid[1]), .req_valid_E(valid[2]),
        .req_valid_S(valid[3]), .req_valid_W(valid[4]),
        .request_L(req[0]), .request_N(req[1]), .request_E(req[2]),
        .request_S(req[3]), .request_W(req[4]),
        .tail_L(tail[0]), .tail_N(tail[1]), .tail_E(tail[2]), .tail_S(tail[3]), .tail_W(tail[4]),
        .full_L(full[0]), .full_N(full[1]), .full_E(full[2]), .full_S(full[3]), .full_W(full[4]),
        .grant_L(g_l), .grant_N(g_n), .grant_E(g_e), .grant_S(g_s), .grant_W(g_w),
        .select_L(s_l), .select_N(s_n), .select_E(s_e), .select_S(s_s), .select_W(s_w),
        .lock_L(k_l), .lock_N(k_n), .lock_E(k_e), .lock_S(k_s), .lock_W(k_w)
    );

    wire [4:0]  dut_grant = {g_w, g_s, g_e, g_n, g_l};
    wire [4:0]  dut_lock  = {k_w, k_s, k_e, k_n, k_l};
    wire [14:0] dut_sel   = {s_w, s_s, s_e, s_n, s_l};

    // Output index order L,N,E,S,W -> direction code carried by flits
    int code_of [5] = '{0, 3, 1, 4, 2};

    // Reference model: per-output owner (-1 = free) and round-robin pointer
    int owner [5];
    int ptr   [5];

    // Packet generator state per input
    bit pk_active [5];
    bit pk_illegal [5];
    int pk_dest [5];
    int pk_rem [5];
    bit random_mode = 1'b0;
    bit full_force [5];

    exp_t sb [$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    endtask

    always @(negedge clk) begin
        if (!rst && sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("grant", {11'd0, dut_grant}, {11'd0, e.grant});
            check("select", {1'b0, dut_sel}, {1'b0, e.sel});
            check("lock", {11'd0, dut_lock}, {11'd0, e.lock});
        end
    end

    task automatic model_reset();
        for (int o = 0; o < 5; o++) begin
            owner[o] = -1;
            ptr[o]   = 0;
        end
        for (int i = 0; i < 5; i++) pk_active[i] = 1'b0;
    endtask

    task automatic load_pkt(input int i, input int dest, input int len);
        pk_active[i]  = 1'b1;
        pk_dest[i]    = dest;
        pk_rem[i]     = len;
        pk_illegal[i] = (dest > 4);
    endtask

    task automatic step();
        exp_t e;
        bit [4:0] gin;
        // Random packet starts and per-input drive
        for (int i = 0; i < 5; i++) begin
            if (random_mode && !pk_active[i] && ($urandom % 3 == 0)) begin
                int d;
                d = $urandom_range(0, 7);
                load_pkt(i, d, (d > 4) ? $urandom_range(1, 6) : $urandom_range(1, 4));
            end
            if (pk_active[i]) begin
                valid[i] = pk_illegal[i] ? 1'b1 : (random_mode ? ($urandom % 4 != 0) : 1'b1);
                req[i]   = 3'(pk_dest[i]);
                tail[i]  = !pk_illegal[i] && (pk_rem[i] == 1);
            end else begin
                valid[i] = 1'b0;
                req[i]   = 3'($urandom_range(0, 7));
                tail[i]  = 1'($urandom);
            end
        end
        for (int o = 0; o < 5; o++) full[o] = random_mode ? ($urandom % 4 == 0) : full_force[o];

        // Expected outputs this cycle from model state
        gin = '0;
        for (int o = 0; o < 5; o++) begin
            e.lock[o]        = (owner[o] >= 0);
            e.sel[o*3 +: 3]  = (owner[o] >= 0) ? 3'(owner[o]) : 3'd5;
            if (owner[o] >= 0 && valid[owner[o]] && !full[o]) gin[owner[o]] = 1'b1;
        end
        e.grant = gin;
        sb.push_back(e);

        // Model transition at the coming edge
        for (int o = 0; o < 5; o++) begin
            if (owner[o] >= 0) begin
                if (gin[owner[o]] && tail[owner[o]]) owner[o] = -1;
            end else begin
                for (int k = 0; k < 5; k++) begin
                    int i;
                    i = (ptr[o] + k) % 5;
                    if (owner[o] < 0 && valid[i] && int'(req[i]) == code_of[o]) begin
                        owner[o] = i;
                        ptr[o]   = (i + 1) % 5;
                    end
                end
            end
        end

        // Generator consumes transferred flits
        for (int i = 0; i < 5; i++) begin
            if (pk_active[i] && (pk_illegal[i] || gin[i])) begin
                pk_rem[i]--;
                if (pk_rem[i] == 0) pk_active[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_select", {1'b0, dut_sel}, {1'b0, {5{3'd5}}});
        check("rst_lock", {11'd0, dut_lock}, 16'd0);
        check("rst_grant", {11'd0, dut_grant}, 16'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        valid = '0; tail = '0; full = '0;
        for (int i = 0; i < 5; i++) begin
            req[i] = 3'd0;
            full_force[i] = 1'b0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_select", {1'b0, dut_sel}, {1'b0, {5{3'd5}}});
        check("init_lock", {11'd0, dut_lock}, 16'd0);
        rst = 1'b0;

        load_pkt(0, 1, 3);                 // L -> OUT_E, three flits
        run(6);
        load_pkt(2, 4, 6);                 // E -> OUT_S with backpressure
        run(2);
        full_force[3] = 1'b1;
        run(4);
        full_force[3] = 1'b0;
        run(8);
        load_pkt(0, 3, 3); load_pkt(1, 4, 3); load_pkt(2, 2, 3);
        load_pkt(3, 1, 3); load_pkt(4, 0, 3);
        run(6);
        load_pkt(2, 2, 5);                 // E -> OUT_W, reset while locked
        run(2);
        check("lock_W_before_rst", {15'd0, k_w}, 16'd1);
        do_reset();
        load_pkt(1, 0, 1); load_pkt(3, 0, 1); load_pkt(4, 0, 1);
        run(6);
        check("ptr_L_wrap", 16'(ptr[0]), 16'd0);
        load_pkt(1, 6, 10); load_pkt(0, 1, 2);
        run(12);

        random_mode = 1'b1;
        run(1500);
        do_reset();
        run(1500);
        random_mode = 1'b0;
        run(40);
        repeat (2) @(posedge clk);
        check("scoreboard_drained", 16'(sb.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wormhole_switch_allocator.md
Name: wormhole_switch_allocator

Overview:
- Per-output round-robin switch allocator with wormhole locking for the 5-port router (L, N, E, S, W).
- Each output port is granted to one input for a whole packet, head to tail flit, and released on the tail.
- Drives the crossbar select lines and the per-input grant (dequeue) signals.
- Replaces the fixed-scan allocator that sits between the input buffers and the crossbar.

Parameters:
- N_BIT_SEL, 3, width of each crossbar select code.
- N_REGISTER, 3, width of each route/direction request code.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid_L/N/E/S/W  in  1 each  input buffer holds a flit wanting an output.
- request_L/N/E/S/W  in  N_REGISTER each  requested output code: OUT_L=0, OUT_E=1, OUT_W=2, OUT_N=3, OUT_S=4; codes 5-7 are illegal.
- tail_L/N/E/S/W  in  1 each  the head-of-buffer flit is a packet tail.
- full_L/N/E/S/W  in  1 each  downstream buffer of that output is full.
- grant_L/N/E/S/W  out  1 each  the flit at that input transfers at this clock edge.
- select_L/N/E/S/W  out  N_BIT_SEL each  input driving that output: IN_L=0, IN_N=1, IN_E=2, IN_S=3, IN_W=4, IN_NON=5.
- lock_L/N/E/S/W  out  1 each  that output is currently owned by a packet.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: all select_* = IN_NON, all lock_* = 0, all grant_* = 0, all RR pointers = 0 (input L). Reset mid-packet drops all locks immediately.
- Each output o has a 2-state FSM, IDLE and LOCKED, plus a 3-bit RR pointer in range 0..4.
- Input index order is L=0, N=1, E=2, S=3, W=4.
- Eligibility: input i is eligible for output o when req_valid_i=1 and request_i equals code(o). Illegal codes are never eligible and never granted.
- IDLE: if any input is eligible, pick the first eligible index scanning ptr, ptr+1, ... mod 5.
- IDLE -> LOCKED at the next edge, with:
  - select_o <= winner encoding, lock_o <= 1;
  - ptr_o <= (winner+1) mod 5.
  - If nothing is eligible, stay IDLE with select_o = IN_NON.
- LOCKED, grant: grant_owner = req_valid_owner & ~full_o.
  - Grant is combinational from registered state and inputs; there are no other grant paths.
  - A flit transfers on each edge where grant is 1.
- LOCKED -> IDLE: at an edge where grant_owner=1 and tail_owner=1. Then select_o <= IN_NON and lock_o <= 0.
- Latency:
  - head flit valid at cycle t gives lock at t+1 and the earliest grant in cycle t+1;
  - after a tail transfer at edge t, re-arbitration runs in cycle t+1 and the next owner's earliest grant is in cycle t+2.
- full_o=1 holds grant low and keeps the lock; data is never dropped.
- req_valid_owner=0 mid-packet (bubble) holds the lock; grant stays 0.
- Single-flit packets (head = tail) lock for exactly one transfer cycle when not full.
- Outputs are independent:
  - up to 5 outputs may lock in the same cycle to 5 distinct inputs;
  - an input requests one output at a time, so it never owns two outputs.
- Simultaneous requests from several inputs for the same IDLE output: exactly one winner. Losers keep waiting; there is no grant to them.
- U-turn (input X requesting output X) is allowed; it is not filtered here.
- Select codes fit N_BIT_SEL=3; the RR pointer wraps 4 -> 0.

Decomposition:
- Shared package noc_pkg:
  - OUT_* direction codes and IN_* / IN_NON select codes;
  - port index constants L..W;
  - an alloc_state type {IDLE, LOCKED}.
- One natural sub-module: rr_out_arbiter.
  - Contains one output's FSM, RR pointer and select register.
  - Inputs: 5-bit eligible vector, tail/valid of owner, full.
  - The top level instantiates 5 copies and ORs the per-output grant vectors.

Test Plan:
1. Single packet: L requests OUT_E, 3 flits with tail on the 3rd, full_E=0 -> lock_E=1 and select_E=0 at t+1; grant_L high for 3 cycles; select_E=IN_NON after the tail.
2. Contention: N, S, W all request OUT_L with single-flit packets and ptr_L=0 -> owners in order N(1), S(3), W(4); pointer ends at 0; no overlapping grants.
3. Backpressure: E locked to output S, full_S=1 for 4 cycles mid-packet -> grant_E=0 and lock_S=1 throughout; transfer resumes the cycle full_S drops.
4. Parallel: L->N, N->S, E->W, S->E, W->L requested at once -> all five lock_* = 1 at t+1; five grants per cycle.
5. Reset mid-packet: assert rst while lock_W=1 -> all select_* = 5, grant_* = 0 and lock_* = 0 asynchronously; pointers = 0.
6. Illegal code: request_N=3'd6 with req_valid_N=1 for 10 cycles -> no lock, grant_N=0, no effect on other ports.
